// File: rtl/bin_onehot_pipe.sv
// -----------------------------------------------------------------------------
// bin_onehot_pipe
// Per-word binary <-> one-hot converter feeding a 2-entry result FIFO.
//   mode_i = 0 : decode, data_o = 1 << data_i[BIN_W-1:0], err_o = 0
//   mode_i = 1 : encode, data_o = index of lowest set bit (zero-extended),
//                err_o = 1 unless exactly one bit of data_i is set
//
// Optional feature: define ONEHOT_ERR_CNT_EN to add err_cnt_o, a saturating
// count of error results handed to the consumer.
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-high; empties the FIFO, zeroes outputs
//   in_valid_i   word offered          in_ready_o  FIFO has a free slot
//   mode_i       0 = decode, 1 = encode
//   data_i       input word (OH_W bits)
//   out_valid_o  result available      out_ready_i consumer takes result
//   data_o       result (OH_W bits)    err_o       result flagged invalid
//   err_cnt_o    saturating error count (ONEHOT_ERR_CNT_EN only)
// -----------------------------------------------------------------------------
module bin_onehot_pipe #(
  parameter int BIN_W = 4,
  parameter int OH_W  = 2**BIN_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             mode_i,
  input  logic [OH_W-1:0]  data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OH_W-1:0]  data_o,
  output logic             err_o
`ifdef ONEHOT_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt_o
`endif
);

  // Returns {err, index}: index of the lowest set bit, err when the word
  // is all zeros or has more than one bit set.
  function automatic logic [BIN_W:0] onehot_encode(input logic [OH_W-1:0] word);
    logic [BIN_W-1:0] idx;
    logic             found;
    logic             multi;
    idx   = {BIN_W{1'b0}};
    found = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < OH_W; i++) begin
      if (word[i]) begin
        if (found) begin
          multi = 1'b1;
        end else begin
          idx   = BIN_W'(i);
          found = 1'b1;
        end
      end
    end
    return {(~found) | multi, idx};
  endfunction

  logic [BIN_W:0]    enc_s;
  logic [OH_W-1:0]   res_data_s;
  logic              res_err_s;

  logic [1:0]        count_r;
  logic              ready_r;
  logic              valid_r;
  logic [OH_W-1:0]   head_data_r;
  logic              head_err_r;
  logic [OH_W-1:0]   tail_data_r;
  logic              tail_err_r;

  logic [1:0]        count_next_s;
  logic [OH_W-1:0]   head_data_next_s;
  logic              head_err_next_s;
  logic [OH_W-1:0]   tail_data_next_s;
  logic              tail_err_next_s;

  logic              push_s;
  logic              pop_s;

  assign enc_s  = onehot_encode(data_i);
  // ready_r/valid_r mirror occupancy, so handshakes never see out_ready_i
  // combinationally on the input side.
  assign push_s = in_valid_i & ready_r;
  assign pop_s  = valid_r & out_ready_i;

  // Convert the offered word into its result and error flag.
  always_comb begin
    res_data_s = {OH_W{1'b0}};
    res_err_s  = 1'b0;
    if (mode_i) begin
      res_data_s = {{(OH_W-BIN_W){1'b0}}, enc_s[BIN_W-1:0]};
      res_err_s  = enc_s[BIN_W];
    end else begin
      res_data_s = {{(OH_W-1){1'b0}}, 1'b1} << data_i[BIN_W-1:0];
      res_err_s  = 1'b0;
    end
  end

  // FIFO next state: the head register always holds the oldest entry so
  // the outputs can come straight from storage.
  always_comb begin
    count_next_s     = count_r;
    head_data_next_s = head_data_r;
    head_err_next_s  = head_err_r;
    tail_data_next_s = tail_data_r;
    tail_err_next_s  = tail_err_r;
    case ({push_s, pop_s})
      2'b10: begin
        if (count_r == 2'd0) begin
          head_data_next_s = res_data_s;
          head_err_next_s  = res_err_s;
        end else begin
          tail_data_next_s = res_data_s;
          tail_err_next_s  = res_err_s;
        end
        count_next_s = count_r + 2'd1;
      end
      2'b01: begin
        head_data_next_s = tail_data_r;
        head_err_next_s  = tail_err_r;
        count_next_s     = count_r - 2'd1;
      end
      2'b11: begin
        // Push with pop only happens below full; with one entry the new
        // word replaces the departing head directly.
        if (count_r == 2'd1) begin
          head_data_next_s = res_data_s;
          head_err_next_s  = res_err_s;
        end else begin
          head_data_next_s = tail_data_r;
          head_err_next_s  = tail_err_r;
          tail_data_next_s = res_data_s;
          tail_err_next_s  = res_err_s;
        end
      end
      default: begin
        count_next_s = count_r;
      end
    endcase
  end

  // FIFO storage and occupancy-derived handshake registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r     <= 2'd0;
      ready_r     <= 1'b1;
      valid_r     <= 1'b0;
      head_data_r <= {OH_W{1'b0}};
      head_err_r  <= 1'b0;
      tail_data_r <= {OH_W{1'b0}};
      tail_err_r  <= 1'b0;
    end else begin
      count_r     <= count_next_s;
      ready_r     <= (count_next_s != 2'd2);
      valid_r     <= (count_next_s != 2'd0);
      head_data_r <= head_data_next_s;
      head_err_r  <= head_err_next_s;
      tail_data_r <= tail_data_next_s;
      tail_err_r  <= tail_err_next_s;
    end
  end

  assign in_ready_o  = ready_r;
  assign out_valid_o = valid_r;
  assign data_o      = head_data_r;
  assign err_o       = head_err_r;

`ifdef ONEHOT_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_r;

  // Count error results as they leave, holding at the maximum value.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_r <= {CNT_W{1'b0}};
    end else if (pop_s && head_err_r && (err_cnt_r != {CNT_W{1'b1}})) begin
      err_cnt_r <= err_cnt_r + CNT_W'(1);
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt_o = err_cnt_r;
`endif

endmodule

// File: tb/tb_bin_onehot_pipe.sv
// -----------------------------------------------------------------------------
// tb_bin_onehot_pipe
// Bench for bin_onehot_pipe (BIN_W = 4). A queue-based reference model
// predicts results and FIFO occupancy; every cycle the DUT outputs are
// compared against it. Directed scenarios plus 1000 randomized words.
// -----------------------------------------------------------------------------
module tb_bin_onehot_pipe;

  localparam int BIN_W = 4;
  localparam int OH_W  = 16;
`ifdef ONEHOT_ERR_CNT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 8;
`endif

  logic            clk;
  logic            reset;
  logic            in_valid_i;
  logic            in_ready_o;
  logic            mode_i;
  logic [OH_W-1:0] data_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [OH_W-1:0] data_o;
  logic            err_o;
`ifdef ONEHOT_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_o;
`endif

  int n_checks;
  int n_errors;

  // Model state: queue of {err, data} results, error counter.
  logic [OH_W:0] model_q[$];
  int            model_cnt;

  bin_onehot_pipe #(.BIN_W(BIN_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .mode_i      (mode_i),
    .data_i      (data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .data_o      (data_o),
    .err_o       (err_o)
`ifdef ONEHOT_ERR_CNT_EN
    ,
    .err_cnt_o   (err_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {err, data} from the conversion rules.
  function automatic logic [OH_W:0] ref_result(input logic m, input logic [OH_W-1:0] d);
    logic [OH_W-1:0] lowbit;
    int              ones;
    if (!m) return {1'b0, 16'(32'd1 << d[3:0])};
    ones = $countones(d);
    if (ones == 0) return {1'b1, 16'h0000};
    lowbit = d & (~d + 16'd1);
    return {(ones != 1), 16'($clog2(lowbit))};
  endfunction

  // One clock cycle: drive inputs, compare outputs with the model, then
  // advance the model by the transfers the protocol implies.
  task automatic step(input logic rst, input logic v, input logic m,
                      input logic [OH_W-1:0] d, input logic ordy, output logic acc);
    logic          mpush;
    logic          mpop;
    logic [OH_W:0] head;
    reset       = rst;
    in_valid_i  = v;
    mode_i      = m;
    data_i      = d;
    out_ready_i = ordy;
    #1;
    chk("in_ready", 32'(in_ready_o), 32'(model_q.size() < 2));
    chk("out_valid", 32'(out_valid_o), 32'(model_q.size() > 0));
    if (model_q.size() > 0) begin
      head = model_q[0];
      chk("data", 32'(data_o), 32'(head[OH_W-1:0]));
      chk("err", 32'(err_o), 32'(head[OH_W]));
    end
`ifdef ONEHOT_ERR_CNT_EN
    chk("err_cnt", 32'(err_cnt_o), 32'(model_cnt));
`endif
    mpush = !rst && v && (model_q.size() < 2);
    mpop  = !rst && ordy && (model_q.size() > 0);
    acc   = mpush;
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      model_cnt = 0;
    end else begin
      if (mpop) begin
        head = model_q.pop_front();
        if (head[OH_W] && model_cnt < (2**CNT_W - 1)) model_cnt++;
      end
      if (mpush) model_q.push_back(ref_result(m, d));
    end
    @(negedge clk);
  endtask

  logic            acc;
  logic            pend_v;
  logic            pend_m;
  logic [OH_W-1:0] pend_d;
  int              accepted;
  int              cycles;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    model_cnt = 0;
    reset       = 1'b1;
    in_valid_i  = 1'b0;
    mode_i      = 1'b0;
    data_i      = 16'h0000;
    out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
`ifdef ONEHOT_ERR_CNT_EN
    chk("rst_cnt", 32'(err_cnt_o), 32'd0);
`endif
    reset = 1'b0;

    // Decode sweep, upper bits randomized to show they are ignored.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, {12'($urandom), 4'(i)}, 1'b1, acc);
      chk("sweep_acc", 32'(acc), 32'd1);
    end
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, acc);

    // Encode: zero, multi-bit, and every single bit.
    step(1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, acc);
    step(1'b0, 1'b1, 1'b1, 16'h0A00, 1'b1, acc);
    for (int i = 0; i < 16; i++) begin
      logic [OH_W-1:0] w;
      w = 16'h0001 << i;
      step(1'b0, 1'b1, 1'b1, w, 1'b1, acc);
    end
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, acc);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, acc);

    // Backpressure: three offers with consumer stalled, third rejected.
    step(1'b0, 1'b1, 1'b0, 16'h0003, 1'b0, acc);
    step(1'b0, 1'b1, 1'b1, 16'h0020, 1'b0, acc);
    step(1'b0, 1'b1, 1'b0, 16'h000E, 1'b0, acc);
    chk("bp_third_rejected", 32'(acc), 32'd0);
    step(1'b0, 1'b1, 1'b0, 16'h000E, 1'b0, acc);
    // Full with pop: third still refused this cycle, accepted the next.
    step(1'b0, 1'b1, 1'b0, 16'h000E, 1'b1, acc);
    step(1'b0, 1'b1, 1'b0, 16'h000E, 1'b1, acc);
    chk("bp_third_taken", 32'(acc), 32'd1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, acc);

    // Reset while full with an offered word and ready consumer.
    step(1'b0, 1'b1, 1'b0, 16'h0005, 1'b0, acc);
    step(1'b0, 1'b1, 1'b1, 16'h0300, 1'b0, acc);
    step(1'b1, 1'b1, 1'b0, 16'h0007, 1'b1, acc);
    chk("mid_rst_data", 32'(data_o), 32'd0);
    chk("mid_rst_err", 32'(err_o), 32'd0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, acc);

    // Error results: held results must not count, popped ones saturate.
    step(1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, acc);
    repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, acc);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, acc);
    repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, acc);

    // Random traffic; an offered word is held until it is accepted.
    accepted = 0;
    cycles   = 0;
    pend_v   = 1'b0;
    pend_m   = 1'b0;
    pend_d   = 16'h0000;
    while (accepted < 1000 && cycles < 20000) begin
      if (!pend_v && ($urandom_range(0, 3) != 0)) begin
        pend_v = 1'b1;
        pend_m = 1'($urandom);
        case ($urandom_range(0, 3))
          0:       pend_d = 16'h0001 << $urandom_range(0, 15);
          1:       pend_d = 16'h0000;
          default: pend_d = 16'($urandom);
        endcase
      end
      step(1'b0, pend_v, pend_m, pend_d, 1'($urandom_range(0, 2) != 0), acc);
      if (acc) begin
        accepted++;
        pend_v = 1'b0;
      end
      cycles++;
    end
    chk("random_done", 32'(accepted), 32'd1000);
    repeat (4) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, acc);
    chk("drained", 32'(out_valid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
